// File: rtl/servo_pkg.sv
// Shared constants, types and helper functions for the servo motion controller.
// Default timing targets a 100 MHz clock: 20 ms frame, 1 ms pulse at 0 deg.
package servo_pkg;

    localparam int unsigned ANGLE_W           = 8;
    localparam int unsigned DEF_PERIOD_CYC    = 2_000_000;
    localparam int unsigned DEF_MIN_PULSE_CYC = 100_000;
    localparam int unsigned DEF_CYC_PER_DEG   = 555;
    localparam int unsigned DEF_MAX_ANGLE     = 180;
    localparam int unsigned DEF_HOME_ANGLE    = 90;
    localparam int unsigned DEF_STEP_DEG      = 2;

    typedef logic [ANGLE_W-1:0] angle_t;
    typedef logic [31:0]        pulse_t;

    // Pulse width in clock cycles for a given angle; 32-bit unsigned arithmetic.
    function automatic pulse_t angle_to_pulse(input angle_t angle,
                                              input pulse_t min_pulse,
                                              input pulse_t cyc_per_deg);
        return min_pulse + pulse_t'(angle) * cyc_per_deg;
    endfunction

    // One frame of slew: move cur toward tgt by at most step; step of 0 jumps.
    function automatic angle_t slew_step(input angle_t cur,
                                         input angle_t tgt,
                                         input angle_t step);
        angle_t res;
        res = tgt;
        if (step != '0) begin
            if (tgt > cur) begin
                if ((tgt - cur) > step) res = cur + step;
            end else begin
                if ((cur - tgt) > step) res = cur - step;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/servo_motion_controller_if.sv
// Command channel between the command source (gesture_to_servo) and the
// servo controller.
// Handshake: a command transfers on a rising clock edge where cmd_valid and
// cmd_ready are both high. The master holds cmd_valid, cmd_chan and
// cmd_angle stable until that transfer; cmd_ready does not depend on
// cmd_valid.
interface servo_motion_controller_if #(
    parameter int unsigned NUM_SERVOS = 4
);
    import servo_pkg::*;

    localparam int unsigned CHAN_W = (NUM_SERVOS > 1) ? $clog2(NUM_SERVOS) : 1;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [CHAN_W-1:0] cmd_chan;
    angle_t            cmd_angle;

    modport master (output cmd_valid, output cmd_chan, output cmd_angle,
                    input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_chan, input  cmd_angle,
                    output cmd_ready);

endinterface

// File: rtl/servo_slew_channel.sv
// One servo channel: target/current angle, slew toward target once per frame,
// PWM compare against the shared frame counter, and in-position flag.
// Pulse length and enable are latched only at the frame boundary so a pulse in
// flight is never cut short or stretched.
module servo_slew_channel
    import servo_pkg::*;
#(
    parameter int unsigned MIN_PULSE_CYC = DEF_MIN_PULSE_CYC,
    parameter int unsigned CYC_PER_DEG   = DEF_CYC_PER_DEG,
    parameter int unsigned HOME_ANGLE    = DEF_HOME_ANGLE,
    parameter int unsigned STEP_DEG      = DEF_STEP_DEG
) (
    input  logic   clk_100mhz,
    input  logic   rst_n,
    input  logic   boundary,
    input  pulse_t cnt,
    input  logic   wr_en,
    input  angle_t wr_angle,
    input  logic   enable,
    output logic   servo_pwm,
    output logic   in_position
);

    localparam angle_t HOME      = angle_t'(HOME_ANGLE);
    localparam angle_t STEP      = angle_t'(STEP_DEG);
    localparam pulse_t MIN_PULSE = pulse_t'(MIN_PULSE_CYC);
    localparam pulse_t PER_DEG   = pulse_t'(CYC_PER_DEG);

    angle_t target_q;
    angle_t cur_q;
    angle_t cur_next;
    pulse_t pulse_len_q;
    logic   en_q;

    // A disabled channel holds its current angle across the boundary.
    assign cur_next = enable ? slew_step(cur_q, target_q, STEP) : cur_q;

    // Channel state: target write on accept, slew and latch at frame boundary.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            target_q    <= HOME;
            cur_q       <= HOME;
            pulse_len_q <= angle_to_pulse(HOME, MIN_PULSE, PER_DEG);
            en_q        <= 1'b0;
            servo_pwm   <= 1'b0;
            in_position <= 1'b1;
        end else begin
            if (wr_en) begin
                target_q <= wr_angle;
            end
            if (boundary) begin
                en_q        <= enable;
                cur_q       <= cur_next;
                pulse_len_q <= angle_to_pulse(cur_next, MIN_PULSE, PER_DEG);
            end
            servo_pwm   <= en_q && (cnt < pulse_len_q);
            in_position <= (cur_q == target_q);
        end
    end

endmodule

// File: rtl/servo_motion_controller.sv
// N-channel 50 Hz servo driver: shared frame counter, command decode with
// clamping/drop reporting, and one slew channel per servo.
module servo_motion_controller
    import servo_pkg::*;
#(
    parameter int unsigned NUM_SERVOS    = 4,
    parameter int unsigned PERIOD_CYC    = DEF_PERIOD_CYC,
    parameter int unsigned MIN_PULSE_CYC = DEF_MIN_PULSE_CYC,
    parameter int unsigned CYC_PER_DEG   = DEF_CYC_PER_DEG,
    parameter int unsigned MAX_ANGLE     = DEF_MAX_ANGLE,
    parameter int unsigned HOME_ANGLE    = DEF_HOME_ANGLE,
    parameter int unsigned STEP_DEG      = DEF_STEP_DEG
) (
    input  logic                    clk_100mhz,
    input  logic                    rst_n,
    servo_motion_controller_if.slave cmd,
    input  logic [NUM_SERVOS-1:0]   enable,
    output logic [NUM_SERVOS-1:0]   servo_pwm,
    output logic [NUM_SERVOS-1:0]   in_position,
    output logic                    frame_tick,
    output logic                    cmd_error
);

    localparam int unsigned CNT_W = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CYC - 1);
    localparam angle_t MAX_A = angle_t'(MAX_ANGLE);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_next;
    logic             boundary;
    logic             ready_q;
    logic             accept;
    logic             chan_bad;
    logic             angle_bad;
    angle_t           wr_angle;
    pulse_t           cnt_ext;

    assign boundary  = (cnt_q == CNT_LAST);
    assign cnt_next  = boundary ? '0 : cnt_q + CNT_W'(1);
    assign cnt_ext   = pulse_t'(cnt_q);

    assign cmd.cmd_ready = ready_q;
    assign accept    = cmd.cmd_valid && ready_q;
    assign chan_bad  = (32'(cmd.cmd_chan) >= NUM_SERVOS);
    assign angle_bad = (cmd.cmd_angle > MAX_A);
    assign wr_angle  = angle_bad ? MAX_A : cmd.cmd_angle;

    // Frame counter plus the status strobes that are timed off it.
    // ready is low in the reset-release cycle (its reset value) and in the
    // boundary cycle so a command never races the per-frame slew update.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            frame_tick <= 1'b0;
            cmd_error  <= 1'b0;
        end else begin
            cnt_q      <= cnt_next;
            ready_q    <= (cnt_next != CNT_LAST);
            frame_tick <= (cnt_next == '0);
            cmd_error  <= accept && (chan_bad || angle_bad);
        end
    end

    for (genvar g = 0; g < int'(NUM_SERVOS); g++) begin : g_chan
        logic wr_en;
        assign wr_en = accept && !chan_bad && (32'(cmd.cmd_chan) == 32'(g));

        servo_slew_channel #(
            .MIN_PULSE_CYC (MIN_PULSE_CYC),
            .CYC_PER_DEG   (CYC_PER_DEG),
            .HOME_ANGLE    (HOME_ANGLE),
            .STEP_DEG      (STEP_DEG)
        ) u_chan (
            .clk_100mhz  (clk_100mhz),
            .rst_n       (rst_n),
            .boundary    (boundary),
            .cnt         (cnt_ext),
            .wr_en       (wr_en),
            .wr_angle    (wr_angle),
            .enable      (enable[g]),
            .servo_pwm   (servo_pwm[g]),
            .in_position (in_position[g])
        );
    end

endmodule

// File: tb/tb_servo_motion_controller.sv
// Bench for servo_motion_controller with a shortened frame (1000 cycles).
// A frame-level reference model tracks target/current angle per channel and
// predicts each frame's pulse width, which is compared against the measured
// high time of servo_pwm.
module tb_servo_motion_controller;
    import servo_pkg::*;

    localparam int N      = 4;
    localparam int N3     = 3;
    localparam int PERIOD = 1000;
    localparam int MINP   = 50;
    localparam int CPD    = 2;
    localparam int MAXA   = 180;
    localparam int HOME   = 90;
    localparam int STEP   = 10;

    // ---------------- clock / reset ----------------
    logic clk_100mhz = 1'b0;
    logic rst_n      = 1'b1;
    always #5 clk_100mhz = ~clk_100mhz;

    logic [N-1:0]  enable;
    logic [N-1:0]  servo_pwm;
    logic [N-1:0]  in_position;
    logic          frame_tick;
    logic          cmd_error;
    logic [N3-1:0] enable3;
    logic [N3-1:0] servo_pwm3;
    logic [N3-1:0] in_position3;
    logic          frame_tick3;
    logic          cmd_error3;

    servo_motion_controller_if #(.NUM_SERVOS(N))  cmd_if ();
    servo_motion_controller_if #(.NUM_SERVOS(N3)) cmd3_if ();

    servo_motion_controller #(
        .NUM_SERVOS(N), .PERIOD_CYC(PERIOD), .MIN_PULSE_CYC(MINP),
        .CYC_PER_DEG(CPD), .MAX_ANGLE(MAXA), .HOME_ANGLE(HOME), .STEP_DEG(STEP)
    ) u_dut (
        .clk_100mhz(clk_100mhz), .rst_n(rst_n), .cmd(cmd_if),
        .enable(enable), .servo_pwm(servo_pwm), .in_position(in_position),
        .frame_tick(frame_tick), .cmd_error(cmd_error)
    );

    // Three-channel instance: the only way to present an out-of-range channel.
    servo_motion_controller #(
        .NUM_SERVOS(N3), .PERIOD_CYC(PERIOD), .MIN_PULSE_CYC(MINP),
        .CYC_PER_DEG(CPD), .MAX_ANGLE(MAXA), .HOME_ANGLE(HOME), .STEP_DEG(STEP)
    ) u_dut3 (
        .clk_100mhz(clk_100mhz), .rst_n(rst_n), .cmd(cmd3_if),
        .enable(enable3), .servo_pwm(servo_pwm3), .in_position(in_position3),
        .frame_tick(frame_tick3), .cmd_error(cmd_error3)
    );

    // ---------------- reference model / scoreboard ----------------
    int          k;             // cycles since reset release (cnt = k % PERIOD)
    int          tgt_m[N];
    int          cur_m[N];
    bit          en_m[N];
    logic [N-1:0] exp_inpos;
    logic        exp_err;
    logic        exp_tick;
    logic [31:0] exp_q[$];      // expected pulse width per channel per frame
    int          width_acc[N];
    int          last_w[N];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    endtask

    function automatic bit ready_at(input int kk);
        return !(kk == 0 || (kk % PERIOD) == PERIOD - 1);
    endfunction

    function automatic int toward(input int cur, input int tgt);
        int d;
        d = tgt - cur;
        if (STEP == 0) return tgt;
        if (d > STEP)  d = STEP;
        if (d < -STEP) d = -STEP;
        return cur + d;
    endfunction

    task automatic model_reset();
        k = 0;
        for (int i = 0; i < N; i++) begin
            tgt_m[i] = HOME; cur_m[i] = HOME; en_m[i] = 1'b0;
            width_acc[i] = 0; last_w[i] = -1;
        end
        exp_q.delete();
        for (int i = 0; i < N; i++) exp_q.push_back(32'd0);
        exp_inpos = '1; exp_err = 1'b0; exp_tick = 1'b0;
    endtask

    task automatic check_sample();
        logic [31:0] exp_w;
        check_eq("cmd_ready", 32'(cmd_if.cmd_ready), 32'(ready_at(k)));
        check_eq("frame_tick", 32'(frame_tick), 32'(exp_tick));
        check_eq("cmd_error", 32'(cmd_error), 32'(exp_err));
        check_eq("in_position", 32'(in_position), 32'(exp_inpos));
        for (int i = 0; i < N; i++) width_acc[i] += int'(servo_pwm[i]);
        if ((k % PERIOD) == PERIOD - 1) begin
            for (int i = 0; i < N; i++) begin
                exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
                check_eq($sformatf("pulse_w[%0d]", i), 32'(width_acc[i]), exp_w);
                last_w[i] = width_acc[i];
                width_acc[i] = 0;
            end
        end
    endtask

    // Apply the effect of the clock edge closing cycle k, advance, then check.
    task automatic step();
        int c;
        for (int i = 0; i < N; i++) exp_inpos[i] = (cur_m[i] == tgt_m[i]);
        exp_err = 1'b0;
        if (cmd_if.cmd_valid && ready_at(k)) begin
            c = int'(cmd_if.cmd_chan);
            if (c >= N) exp_err = 1'b1;
            else if (int'(cmd_if.cmd_angle) > MAXA) begin
                tgt_m[c] = MAXA; exp_err = 1'b1;
            end else tgt_m[c] = int'(cmd_if.cmd_angle);
        end
        if ((k % PERIOD) == PERIOD - 1) begin
            for (int i = 0; i < N; i++) begin
                en_m[i] = enable[i];
                if (enable[i]) cur_m[i] = toward(cur_m[i], tgt_m[i]);
                exp_q.push_back(en_m[i] ? 32'(MINP + CPD * cur_m[i]) : 32'd0);
            end
        end
        exp_tick = (((k + 1) % PERIOD) == 0);
        @(negedge clk_100mhz);
        k++;
        check_sample();
    endtask

    // ---------------- driver tasks ----------------
    task automatic run_cycles(input int n);
        for (int t = 0; t < n; t++) step();
    endtask

    task automatic run_to_cnt(input int c);
        for (int t = 0; t <= PERIOD; t++) begin
            if ((k % PERIOD) == c) break;
            step();
        end
    endtask

    task automatic send_cmd(input int chan, input int angle, output int waited);
        bit rdy;
        bit done;
        done = 1'b0;
        waited = 0;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_chan  = chan[1:0];
        cmd_if.cmd_angle = angle[7:0];
        for (int t = 0; t < 8; t++) begin
            rdy = cmd_if.cmd_ready;
            step();
            if (rdy) begin done = 1'b1; break; end
            waited++;
        end
        check_eq("cmd_accepted", 32'(done), 32'd1);
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        cmd_if.cmd_valid  = 1'b0;
        cmd3_if.cmd_valid = 1'b0;
        @(negedge clk_100mhz);
        rst_n = 1'b0;
        #1;
        check_eq("rst_pwm", 32'(servo_pwm), 32'd0);
        check_eq("rst_inpos", 32'(in_position), 32'hF);
        check_eq("rst_tick", 32'(frame_tick), 32'd0);
        check_eq("rst_err", 32'(cmd_error), 32'd0);
        check_eq("rst_ready", 32'(cmd_if.cmd_ready), 32'd0);
        repeat (3) @(negedge clk_100mhz);
        rst_n = 1'b1;
        model_reset();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int waited;
        int r;
        int stop_k;
        cmd_if.cmd_valid  = 1'b0; cmd_if.cmd_chan  = '0; cmd_if.cmd_angle  = '0;
        cmd3_if.cmd_valid = 1'b0; cmd3_if.cmd_chan = '0; cmd3_if.cmd_angle = '0;
        enable  = '1;
        enable3 = '1;
        model_reset();

        // Home position: first frame low, second frame 230-cycle pulses.
        do_reset();
        run_cycles(2 * PERIOD);
        for (int i = 0; i < N; i++) check_eq($sformatf("home_pulse[%0d]", i), 32'(last_w[i]), 32'd230);

        // Out-of-range channel on the 3-channel instance is dropped.
        run_to_cnt(500);
        check_eq("ready3", 32'(cmd3_if.cmd_ready), 32'd1);
        cmd3_if.cmd_valid = 1'b1; cmd3_if.cmd_chan = 2'd3; cmd3_if.cmd_angle = 8'd40;
        step();
        check_eq("drop_err3", 32'(cmd_error3), 32'd1);
        cmd3_if.cmd_valid = 1'b0;
        step();
        check_eq("drop_err3_once", 32'(cmd_error3), 32'd0);
        step();
        check_eq("drop_inpos3", 32'(in_position3), 32'h7);
        cmd3_if.cmd_valid = 1'b1; cmd3_if.cmd_chan = 2'd2; cmd3_if.cmd_angle = 8'd100;
        step();
        check_eq("ok_err3", 32'(cmd_error3), 32'd0);
        cmd3_if.cmd_valid = 1'b0;
        step();
        check_eq("ok_inpos3", 32'(in_position3), 32'h3);
        check_eq("tick3", 32'(frame_tick3), 32'(exp_tick));

        // Ch1 -> 120: 250, 270, 290 over three frames.
        run_to_cnt(0);
        send_cmd(1, 120, waited);
        run_cycles(4 * PERIOD);
        check_eq("ch1_pulse_120", 32'(last_w[1]), 32'd290);
        check_eq("ch1_inpos", 32'(in_position[1]), 32'd1);

        // Ch0 -> 200 clamps to 180, 410-cycle pulse after nine frames.
        run_to_cnt(0);
        send_cmd(0, 200, waited);
        run_cycles(10 * PERIOD);
        check_eq("ch0_pulse_180", 32'(last_w[0]), 32'd410);

        // Command presented in the boundary cycle waits exactly one cycle.
        run_to_cnt(PERIOD - 1);
        send_cmd(2, 50, waited);
        check_eq("stall_cycles", 32'(waited), 32'd1);

        // Disable ch2 mid-pulse, then re-enable to resume the ramp.
        run_to_cnt(100);
        enable[2] = 1'b0;
        run_cycles(3 * PERIOD);
        check_eq("ch2_disabled", 32'(last_w[2]), 32'd0);
        enable[2] = 1'b1;
        run_cycles(5 * PERIOD);

        // Random commands and enable toggles.
        stop_k = k + 20 * PERIOD;
        while (k < stop_k) begin
            r = $urandom_range(0, 299);
            if (r == 0) begin
                send_cmd($urandom_range(0, N - 1), $urandom_range(0, 255), waited);
            end else if (r == 1) begin
                enable[$urandom_range(0, N - 1)] ^= 1'b1;
                step();
            end else begin
                step();
            end
        end
        enable = '1;
        run_cycles(2 * PERIOD);

        // Reset in the middle of a ramp returns to home values.
        send_cmd(3, 0, waited);
        run_cycles(PERIOD + 300);
        do_reset();
        run_cycles(2 * PERIOD);
        for (int i = 0; i < N; i++) check_eq($sformatf("post_reset_pulse[%0d]", i), 32'(last_w[i]), 32'd230);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
